// File: rtl/mr_ctrl_pkg.sv
// Shared definitions for the map/reduce job controller.
//   state_e     : controller state encoding (also exported on o_state)
//   ERR_*       : error codes reported on o_err_code
//   clogb2      : ceiling log2 helper for sizing counters
package mr_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CLEAR  = 3'd1,
        ST_MAP    = 3'd2,
        ST_DRAIN  = 3'd3,
        ST_REDUCE = 3'd4,
        ST_DONE   = 3'd5,
        ST_ERROR  = 3'd6
    } state_e;

    localparam logic [1:0] ERR_NONE     = 2'd0;
    localparam logic [1:0] ERR_ZERO_LEN = 2'd1;
    localparam logic [1:0] ERR_OVERRUN  = 2'd2;
    localparam logic [1:0] ERR_TIMEOUT  = 2'd3;

    function automatic int clogb2(input int value);
        int result;
        int v;
        result = 0;
        v      = value - 1;
        while (v > 0) begin
            result = result + 1;
            v      = v >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/mr_watchdog.sv
// Stall watchdog for the job controller.
//   clk, rst_n : clock, asynchronous active-low reset
//   i_reload   : forces the count back to 0 next cycle (progress seen)
//   i_enable   : counting allowed; when low the count is held at 0
//   i_limit    : stall limit in cycles, 0 disables expiry
//   o_expire   : limit reached this cycle (combinational from count)
// Expiry fires while the count equals limit-1, i.e. exactly i_limit cycles
// after the cycle that requested the last reload.
module mr_watchdog
    import mr_ctrl_pkg::*;
#(
    parameter int TIMEOUT_WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_reload,
    input  logic                     i_enable,
    input  logic [TIMEOUT_WIDTH-1:0] i_limit,
    output logic                     o_expire
);

    logic [TIMEOUT_WIDTH-1:0] count_q;
    logic [TIMEOUT_WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (i_reload || !i_enable) begin
            count_d = '0;
        end else begin
            count_d = count_q + 1'b1;
        end
    end

    // A reload in the same cycle means progress was made, so it suppresses expiry.
    assign o_expire = i_enable && !i_reload && (i_limit != '0) &&
                      (count_q == (i_limit - 1'b1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/mr_job_sequencer.sv
// Job controller for one map/reduce pass over streamed points.
//   i_start/i_abort            : host job control (one-cycle pulses)
//   i_num_pts_expected/i_timeout : job length and stall limit, latched on start
//   i_num_pts, i_fifo_empty, i_mapper_busy, i_reduce_done : datapath status
//   o_res/o_map                : converter count clear / count enable
//   o_reduce_start             : one-cycle reduce kick
//   o_busy/o_done/o_error/o_err_code : host status
//   o_state                    : current state for debug
//   o_cycles                   : cycles spent in MAP+DRAIN+REDUCE
// All outputs are flops loaded from the next-state value, so no input has a
// combinational path to any output.
module mr_job_sequencer
    import mr_ctrl_pkg::*;
#(
    parameter int NUM_MAPPERS   = 4,
    parameter int TIMEOUT_WIDTH = 16,
    parameter int CYCLE_WIDTH   = 32
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     i_start,
    input  logic                     i_abort,
    input  logic [63:0]              i_num_pts_expected,
    input  logic [TIMEOUT_WIDTH-1:0] i_timeout,
    input  logic [63:0]              i_num_pts,
    input  logic                     i_fifo_empty,
    input  logic [NUM_MAPPERS-1:0]   i_mapper_busy,
    input  logic                     i_reduce_done,
    output logic                     o_res,
    output logic                     o_map,
    output logic                     o_reduce_start,
    output logic                     o_busy,
    output logic                     o_done,
    output logic                     o_error,
    output logic [1:0]               o_err_code,
    output logic [2:0]               o_state,
    output logic [CYCLE_WIDTH-1:0]   o_cycles
);

    state_e                   state_q, state_d;
    logic [1:0]               err_code_q, err_code_d;
    logic [63:0]              expected_q, expected_d;
    logic [TIMEOUT_WIDTH-1:0] timeout_q, timeout_d;
    logic [CYCLE_WIDTH-1:0]   cycles_q, cycles_d;
    logic [63:0]              prev_pts_q;
    logic                     res_q, map_q, busy_q, done_q, error_q, reduce_start_q;

    logic watched;
    logic pts_changed;
    logic pts_eq;
    logic pts_over;
    logic drain_ok;
    logic wd_reload;
    logic wd_expire;

    assign watched     = (state_q == ST_MAP) || (state_q == ST_DRAIN) || (state_q == ST_REDUCE);
    assign pts_changed = (i_num_pts != prev_pts_q);
    assign pts_eq      = (i_num_pts == expected_q);
    assign pts_over    = (i_num_pts > expected_q);
    assign drain_ok    = i_fifo_empty && (i_mapper_busy == '0);

    // Reload on every condition that enters a watched state (CLEAR->MAP,
    // MAP->DRAIN, DRAIN->REDUCE) and on point-count progress in MAP. Built from
    // the raw conditions rather than state_d so expiry cannot loop back on itself.
    assign wd_reload = !watched ||
                       ((state_q == ST_MAP) && (pts_changed || pts_eq)) ||
                       ((state_q == ST_DRAIN) && drain_ok);

    mr_watchdog #(
        .TIMEOUT_WIDTH (TIMEOUT_WIDTH)
    ) u_watchdog (
        .clk      (clk),
        .rst_n    (reset_n),
        .i_reload (wd_reload),
        .i_enable (watched),
        .i_limit  (timeout_q),
        .o_expire (wd_expire)
    );

    always_comb begin
        state_d    = state_q;
        err_code_d = err_code_q;
        expected_d = expected_q;
        timeout_d  = timeout_q;
        cycles_d   = cycles_q;

        if (watched && (cycles_q != '1)) begin
            cycles_d = cycles_q + 1'b1;
        end

        if (i_abort) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE, ST_ERROR: begin
                    if (i_start) begin
                        expected_d = i_num_pts_expected;
                        timeout_d  = i_timeout;
                        cycles_d   = '0;
                        if (i_num_pts_expected == '0) begin
                            state_d    = ST_ERROR;
                            err_code_d = ERR_ZERO_LEN;
                        end else begin
                            state_d = ST_CLEAR;
                        end
                    end
                end
                ST_CLEAR: state_d = ST_MAP;
                ST_MAP: begin
                    if (pts_eq) begin
                        state_d = ST_DRAIN;
                    end else if (pts_over) begin
                        state_d    = ST_ERROR;
                        err_code_d = ERR_OVERRUN;
                    end else if (wd_expire) begin
                        state_d    = ST_ERROR;
                        err_code_d = ERR_TIMEOUT;
                    end
                end
                ST_DRAIN: begin
                    if (drain_ok) begin
                        state_d = ST_REDUCE;
                    end else if (wd_expire) begin
                        state_d    = ST_ERROR;
                        err_code_d = ERR_TIMEOUT;
                    end
                end
                ST_REDUCE: begin
                    if (i_reduce_done) begin
                        state_d = ST_DONE;
                    end else if (wd_expire) begin
                        state_d    = ST_ERROR;
                        err_code_d = ERR_TIMEOUT;
                    end
                end
                ST_DONE: state_d = ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end

        // The code is only meaningful while sitting in ERROR.
        if (state_d != ST_ERROR) begin
            err_code_d = ERR_NONE;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= ST_IDLE;
            err_code_q     <= ERR_NONE;
            expected_q     <= '0;
            timeout_q      <= '0;
            cycles_q       <= '0;
            prev_pts_q     <= '0;
            res_q          <= 1'b0;
            map_q          <= 1'b0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            error_q        <= 1'b0;
            reduce_start_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            err_code_q     <= err_code_d;
            expected_q     <= expected_d;
            timeout_q      <= timeout_d;
            cycles_q       <= cycles_d;
            prev_pts_q     <= i_num_pts;
            res_q          <= (state_d == ST_CLEAR);
            map_q          <= (state_d == ST_MAP);
            busy_q         <= (state_d == ST_MAP) || (state_d == ST_DRAIN) || (state_d == ST_REDUCE);
            done_q         <= (state_d == ST_DONE);
            error_q        <= (state_d == ST_ERROR);
            reduce_start_q <= (state_d == ST_REDUCE) && (state_q != ST_REDUCE);
        end
    end

    assign o_res          = res_q;
    assign o_map          = map_q;
    assign o_busy         = busy_q;
    assign o_done         = done_q;
    assign o_error        = error_q;
    assign o_reduce_start = reduce_start_q;
    assign o_err_code     = err_code_q;
    assign o_state        = state_q;
    assign o_cycles       = cycles_q;

endmodule

// File: tb/tb_mr_job_sequencer.sv
// Bench for mr_job_sequencer: directed job scenarios followed by randomized
// traffic, every output compared each cycle against a job-level model.
module tb_mr_job_sequencer;

    localparam int NM = 4;
    localparam int TW = 16;
    localparam int CW = 32;

    localparam int S_IDLE   = 0;
    localparam int S_CLEAR  = 1;
    localparam int S_MAP    = 2;
    localparam int S_DRAIN  = 3;
    localparam int S_REDUCE = 4;
    localparam int S_DONE   = 5;
    localparam int S_ERROR  = 6;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    logic          i_start = 1'b0;
    logic          i_abort = 1'b0;
    logic [63:0]   i_num_pts_expected = '0;
    logic [TW-1:0] i_timeout = '0;
    logic [63:0]   i_num_pts = '0;
    logic          i_fifo_empty = 1'b1;
    logic [NM-1:0] i_mapper_busy = '0;
    logic          i_reduce_done = 1'b0;
    logic          o_res, o_map, o_reduce_start, o_busy, o_done, o_error;
    logic [1:0]    o_err_code;
    logic [2:0]    o_state;
    logic [CW-1:0] o_cycles;

    mr_job_sequencer #(
        .NUM_MAPPERS   (NM),
        .TIMEOUT_WIDTH (TW),
        .CYCLE_WIDTH   (CW)
    ) dut (
        .clk                (clk),
        .reset_n            (reset_n),
        .i_start            (i_start),
        .i_abort            (i_abort),
        .i_num_pts_expected (i_num_pts_expected),
        .i_timeout          (i_timeout),
        .i_num_pts          (i_num_pts),
        .i_fifo_empty       (i_fifo_empty),
        .i_mapper_busy      (i_mapper_busy),
        .i_reduce_done      (i_reduce_done),
        .o_res              (o_res),
        .o_map              (o_map),
        .o_reduce_start     (o_reduce_start),
        .o_busy             (o_busy),
        .o_done             (o_done),
        .o_error            (o_error),
        .o_err_code         (o_err_code),
        .o_state            (o_state),
        .o_cycles           (o_cycles)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // ---------------- job-level model ----------------
    // The watchdog is modelled as a timestamp: m_last_prog is the cycle in
    // which progress last happened; a stall fires when now - m_last_prog
    // reaches the latched timeout.
    int              m_st = S_IDLE;
    int              m_code = 0;
    logic [63:0]     m_exp = '0;
    int              m_to = 0;
    longint unsigned m_cycles = 0;
    logic [63:0]     m_prev_pts = '0;
    bit              m_rs = 1'b0;
    longint          now = 0;
    longint          m_last_prog = 0;

    task automatic model_reset();
        m_st = S_IDLE; m_code = 0; m_exp = '0; m_to = 0;
        m_cycles = 0; m_prev_pts = '0; m_rs = 1'b0;
    endtask

    task automatic model_step();
        bit chg, stalled, drain_ok;
        int nxt, code;
        chg      = (i_num_pts != m_prev_pts);
        stalled  = (m_to != 0) && ((now - m_last_prog) == longint'(m_to));
        drain_ok = i_fifo_empty && (i_mapper_busy == '0);
        nxt  = m_st;
        code = m_code;
        m_rs = 1'b0;
        if (m_st == S_MAP || m_st == S_DRAIN || m_st == S_REDUCE)
            if (m_cycles < 64'hFFFF_FFFF) m_cycles++;
        if (i_abort) begin
            nxt = S_IDLE;
        end else begin
            case (m_st)
                S_IDLE, S_ERROR: if (i_start) begin
                    m_exp = i_num_pts_expected;
                    m_to = int'(i_timeout);
                    m_cycles = 0;
                    if (i_num_pts_expected == 0) begin nxt = S_ERROR; code = 1; end
                    else nxt = S_CLEAR;
                end
                S_CLEAR: begin nxt = S_MAP; m_last_prog = now; end
                S_MAP: begin
                    if (i_num_pts == m_exp) begin nxt = S_DRAIN; m_last_prog = now; end
                    else if (i_num_pts > m_exp) begin nxt = S_ERROR; code = 2; end
                    else if (chg) m_last_prog = now;
                    else if (stalled) begin nxt = S_ERROR; code = 3; end
                end
                S_DRAIN: begin
                    if (drain_ok) begin nxt = S_REDUCE; m_rs = 1'b1; m_last_prog = now; end
                    else if (stalled) begin nxt = S_ERROR; code = 3; end
                end
                S_REDUCE: begin
                    if (i_reduce_done) nxt = S_DONE;
                    else if (stalled) begin nxt = S_ERROR; code = 3; end
                end
                S_DONE: nxt = S_IDLE;
                default: nxt = S_IDLE;
            endcase
        end
        m_code = (nxt == S_ERROR) ? code : 0;
        m_st = nxt;
        m_prev_pts = i_num_pts;
        now++;
    endtask

    // ---------------- scoreboard ----------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        check("o_state",        64'(o_state),        64'(m_st));
        check("o_res",          64'(o_res),          64'(m_st == S_CLEAR));
        check("o_map",          64'(o_map),          64'(m_st == S_MAP));
        check("o_busy",         64'(o_busy),         64'(m_st == S_MAP || m_st == S_DRAIN || m_st == S_REDUCE));
        check("o_done",         64'(o_done),         64'(m_st == S_DONE));
        check("o_error",        64'(o_error),        64'(m_st == S_ERROR));
        check("o_err_code",     64'(o_err_code),     64'(m_code));
        check("o_reduce_start", 64'(o_reduce_start), 64'(m_rs));
        check("o_cycles",       64'(o_cycles),       m_cycles);
    endtask

    // One clock: model predicts, DUT clocks, outputs are compared 1ns later.
    task automatic step();
        model_step();
        @(posedge clk);
        #1;
        compare_all();
    endtask

    // ---------------- driver tasks ----------------
    task automatic quiet_inputs();
        i_start = 1'b0; i_abort = 1'b0; i_reduce_done = 1'b0;
        i_fifo_empty = 1'b1; i_mapper_busy = '0;
    endtask

    // Issues a start and steps through CLEAR; leaves the DUT in its first MAP cycle.
    task automatic start_job(input longint unsigned exp_pts, input int to);
        quiet_inputs();
        i_num_pts = '0;
        i_num_pts_expected = exp_pts;
        i_timeout = TW'(to);
        i_start = 1'b1;
        step();
        i_start = 1'b0;
        step();
    endtask

    task automatic do_abort();
        i_abort = 1'b1;
        step();
        i_abort = 1'b0;
    endtask

    int busy_samples;
    int drain_samples;
    int n;

    initial begin
        // ---- reset ----
        repeat (2) @(posedge clk);
        #1;
        compare_all();
        check("reset_cycles_lit", 64'(o_cycles), 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        step();

        // ---- normal job: expected 8, timeout 100 ----
        start_job(8, 100);
        busy_samples = 1;                       // current sample is the first MAP cycle
        check("s1_map_lit", 64'(o_map), 64'd1);
        check("s1_res_lit", 64'(o_res), 64'd0);
        drain_samples = 0;
        for (int k = 1; k <= 8; k++) begin
            i_num_pts = 64'(k);
            step();
            if (o_busy) busy_samples++;
            if (o_state == 3'(S_DRAIN)) drain_samples++;
        end
        step();                                 // DRAIN -> REDUCE
        if (o_busy) busy_samples++;
        check("s1_drain_len_lit", 64'(drain_samples), 64'd1);
        check("s1_reduce_start_lit", 64'(o_reduce_start), 64'd1);
        for (int k = 0; k < 4; k++) begin
            step();
            if (o_busy) busy_samples++;
        end
        i_reduce_done = 1'b1;
        step();
        i_reduce_done = 1'b0;
        check("s1_done_lit", 64'(o_done), 64'd1);
        check("s1_cycles_lit", 64'(o_cycles), 64'd14);
        check("s1_cycles_measured", 64'(o_cycles), 64'(busy_samples));
        step();
        check("s1_idle_lit", 64'(o_state), 64'(S_IDLE));

        // ---- zero-length job, then abort out of ERROR ----
        quiet_inputs();
        i_num_pts_expected = '0;
        i_start = 1'b1;
        step();
        i_start = 1'b0;
        check("zero_code_lit", 64'(o_err_code), 64'd1);
        check("zero_res_lit", 64'(o_res), 64'd0);
        step();
        do_abort();
        check("zero_abort_code_lit", 64'(o_err_code), 64'd0);
        check("zero_abort_state_lit", 64'(o_state), 64'(S_IDLE));

        // ---- overrun: 3 -> 5 with expected 4 ----
        start_job(4, 100);
        i_num_pts = 64'd3; step();
        i_num_pts = 64'd5; step();
        check("overrun_code_lit", 64'(o_err_code), 64'd2);
        check("overrun_map_lit", 64'(o_map), 64'd0);
        do_abort();

        // ---- stall with timeout 10 ----
        start_job(4, 10);
        i_num_pts = 64'd2; step();              // last progress
        n = 0;
        while (o_error !== 1'b1 && n < 30) begin step(); n++; end
        check("timeout_latency_lit", 64'(n), 64'd10);
        check("timeout_code_lit", 64'(o_err_code), 64'd3);
        do_abort();

        // ---- same stall with watchdog disabled ----
        start_job(4, 0);
        i_num_pts = 64'd2;
        repeat (40) step();
        check("no_timeout_state_lit", 64'(o_state), 64'(S_MAP));
        do_abort();

        // ---- DRAIN held off by a busy mapper; reduce_done ignored in DRAIN ----
        start_job(2, 50);
        i_num_pts = 64'd1; step();
        i_mapper_busy = 4'b0100;
        i_reduce_done = 1'b1;
        i_num_pts = 64'd2; step();              // -> DRAIN
        for (int k = 0; k < 6; k++) begin
            step();
            check("drain_hold_lit", 64'(o_state), 64'(S_DRAIN));
        end
        i_mapper_busy = '0;
        i_reduce_done = 1'b0;
        step();
        check("drain_release_lit", 64'(o_reduce_start), 64'd1);
        // abort in REDUCE
        do_abort();
        check("abort_reduce_done_lit", 64'(o_done), 64'd0);
        check("abort_reduce_state_lit", 64'(o_state), 64'(S_IDLE));

        // ---- abort in MAP; start in MAP ignored ----
        start_job(6, 50);
        i_num_pts_expected = '0;
        i_start = 1'b1; step(); i_start = 1'b0;
        check("start_in_map_lit", 64'(o_state), 64'(S_MAP));
        do_abort();
        check("abort_map_done_lit", 64'(o_done), 64'd0);

        // ---- reset mid-MAP ----
        start_job(6, 50);
        i_num_pts = 64'd1; step();
        reset_n = 1'b0;
        #1;
        model_reset();
        check("rst_outputs_lit", 64'({o_res, o_map, o_reduce_start, o_busy, o_done, o_error,
                                      o_err_code, o_state}), 64'd0);
        check("rst_cycles_lit", 64'(o_cycles), 64'd0);
        compare_all();
        quiet_inputs();
        i_num_pts = '0;
        @(negedge clk);
        reset_n = 1'b1;
        step();

        // ---- randomized traffic ----
        for (int k = 0; k < 3000; k++) begin
            int r;
            i_start = ($urandom_range(0, 7) == 0);
            i_num_pts_expected = ($urandom_range(0, 5) == 0) ? 64'd0 : 64'($urandom_range(1, 10));
            i_timeout = ($urandom_range(0, 2) == 0) ? '0 : TW'($urandom_range(1, 12));
            i_abort = ($urandom_range(0, 99) == 0);
            if (m_st == S_IDLE || m_st == S_CLEAR || m_st == S_ERROR) begin
                i_num_pts = '0;
            end else if (m_st == S_MAP) begin
                r = $urandom_range(0, 9);
                if (r < 5) i_num_pts = i_num_pts + 64'd1;
                else if (r == 5) i_num_pts = i_num_pts + 64'd2;
            end
            i_fifo_empty = ($urandom_range(0, 3) != 0);
            i_mapper_busy = ($urandom_range(0, 1) == 0) ? '0 : NM'($urandom_range(0, 15));
            i_reduce_done = ($urandom_range(0, 4) == 0);
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mr_job_sequencer.md
Name: mr_job_sequencer

Overview:
- Top-level job controller for one map/reduce pass over streamed data points.
- Drives the input converter's i_res (count clear) and i_map (count enable) controls.
- Watches the converter's NUM_PTS point count, the point FIFO and mapper activity, then hands off to the reduce stage.
- Detects zero-length jobs, point overruns and stalls; reports done or error to the host/AXI-lite register block.

Parameters:
- NUM_MAPPERS, 4, number of mapper cores whose busy flags must clear before reduce.
- TIMEOUT_WIDTH, 16, width of the stall watchdog limit and counter.
- CYCLE_WIDTH, 32, width of the job cycle counter.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- i_start  in  1  one-cycle job start request
- i_abort  in  1  one-cycle abort; returns to IDLE
- i_num_pts_expected  in  64  points in this job; sampled on accepted start
- i_timeout  in  TIMEOUT_WIDTH  stall limit in cycles; 0 disables watchdog; sampled on accepted start
- i_num_pts  in  64  converter NUM_PTS
- i_fifo_empty  in  1  point FIFO empty
- i_mapper_busy  in  NUM_MAPPERS  per-mapper busy
- i_reduce_done  in  1  reduce stage finished (pulse or level)
- o_res  out  1  converter count clear
- o_map  out  1  converter count enable
- o_reduce_start  out  1  one-cycle reduce kick
- o_busy  out  1  job in progress
- o_done  out  1  one-cycle completion pulse
- o_error  out  1  error level
- o_err_code  out  2  0 none, 1 zero length, 2 overrun, 3 timeout
- o_state  out  3  current state, for debug
- o_cycles  out  CYCLE_WIDTH  cycles spent in MAP+DRAIN+REDUCE

Behaviour:
- Clock and reset: single clock clk. reset_n is asynchronous and active-low.
- Reset: state IDLE; every output 0; latched expected count, timeout, watchdog and cycle counter all 0. Reset mid-job behaves the same, with no partial pulses.
- Output decode: all control outputs are decoded from registered state only, so there is no combinational path from inputs to outputs.
- State encoding: IDLE=0, CLEAR=1, MAP=2, DRAIN=3, REDUCE=4, DONE=5, ERROR=6.

State transitions:
- IDLE: on i_start, latch i_num_pts_expected and i_timeout, and clear o_cycles.
  - If the expected count is 0: go to ERROR with code 1.
  - Otherwise: go to CLEAR.
- CLEAR: o_res=1 for exactly one cycle, then MAP. i_num_pts is not compared here.
- MAP: o_map=1, o_busy=1.
  - i_num_pts == expected: go to DRAIN.
  - i_num_pts > expected: go to ERROR, code 2.
  - Watchdog expiry: go to ERROR, code 3.
  - Priority: equality > overrun > timeout.
- DRAIN: o_map=0, o_busy=1.
  - Go to REDUCE when i_fifo_empty=1 and i_mapper_busy is all zero in the same cycle.
  - o_reduce_start is high for the single first cycle of REDUCE.
- REDUCE: o_busy=1. On i_reduce_done go to DONE. i_reduce_done is ignored in every other state.
- DONE: o_done=1 for one cycle, then IDLE.
- ERROR: o_error=1 and o_err_code held.
  - i_start re-latches the inputs and follows the IDLE rules; o_error clears on leaving ERROR.
  - i_abort goes to IDLE and clears the error code.

Abort and start handling:
- i_abort in any state goes to IDLE next cycle and has the highest priority.
- i_abort does not pulse o_done or o_reduce_start.
- i_start is ignored outside IDLE and ERROR.

Watchdog:
- Counter reloads to 0 on entry to MAP, DRAIN and REDUCE.
- In MAP it also reloads whenever i_num_pts differs from its value in the previous cycle.
- Otherwise it increments by 1 per cycle.
- Expiry fires when count == timeout-1 and the latched timeout is nonzero, so a stall causes an error exactly timeout cycles after the last progress.
- DRAIN and REDUCE expiry also give code 3. Completion takes priority over expiry in the same cycle.

Cycle counter:
- Increments every cycle in MAP, DRAIN or REDUCE.
- Saturates at all-ones and holds its value after DONE or ERROR until the next accepted start.

Decomposition:
- Shared package mr_ctrl_pkg: state encodings, error-code constants, the clogb2 function.
- Sub-module mr_watchdog: reload, enable, limit and expire; TIMEOUT_WIDTH parameter.
- The FSM and cycle counter live in the top level.

Test Plan:
- Expected=8, timeout=100:
  - Start gives o_res high for 1 cycle, then o_map.
  - Increment i_num_pts 0→8, hold FIFO empty and mappers idle: DRAIN lasts 1 cycle, o_reduce_start fires once.
  - i_reduce_done 5 cycles later gives o_done pulse; o_cycles equals the measured count.
- Expected=0: start gives ERROR, o_err_code=1, and o_res/o_map never assert. A following i_abort returns to IDLE with code 0.
- Expected=4, i_num_pts jumps 3→5: ERROR code 2 next cycle and o_map drops.
- Expected=4, timeout=10, i_num_pts frozen at 2: error code 3 exactly 10 cycles after the last change. With timeout=0 the same stall never errors.
- DRAIN with i_mapper_busy=4'b0100 for 6 cycles: no reduce start. Busy clears: o_reduce_start on the next cycle. i_reduce_done held high during DRAIN is ignored.
- Aborts and reset mid-job:
  - i_abort in MAP and in REDUCE: IDLE next cycle, no o_done.
  - reset_n low mid-MAP: all outputs 0 immediately.
  - i_start in MAP is ignored.
